mcu_bus_bridge: RTL and testbench

Bridges the MCU asynchronous external-memory bus (chip select, output enable, write enable and byte lanes, 16-bit data) into the single-clock register bus consumed by ctrl_bus and the other register slaves. It synchronizes the MCU strobes, produces one-cycle write strobes with byte enables, presents read addresses, and returns registered read data to the MCU data pins. It sits directly upstream of ctrl_bus; read data from all slaves is OR-combined outside this block before reaching `rddata`.

---
 rtl/mcu_bus_bridge_if.sv | 46 ++++
 rtl/mcu_bus_bridge.sv | 200 ++++++++++++++++++++
 tb/tb_mcu_bus_bridge.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mcu_bus_bridge_if.sv
// MCU external-memory pins and register-bus signals of mcu_bus_bridge.
// MCU_NWAIT_EN adds the mcu_nwait wait-request pin.
interface mcu_bus_bridge_if;
  logic        mcu_ne;
  logic        mcu_noe;
  logic        mcu_nwe;
  logic [1:0]  mcu_nbl;
  logic [14:0] mcu_a;
  logic [15:0] mcu_d_in;
  logic [15:0] mcu_d_out;
  logic        mcu_d_oe;
`ifdef MCU_NWAIT_EN
  logic        mcu_nwait;
`endif
  logic [15:0] rdaddr;
  logic [15:0] wraddr;
  logic [1:0]  be;
  logic        write;
  logic [15:0] wrdata;
  logic [15:0] rddata;
  logic        proto_err;

  modport slave (
    input  mcu_ne, mcu_noe, mcu_nwe,
    input  mcu_nbl, mcu_a, mcu_d_in,
    output mcu_d_out, mcu_d_oe,
`ifdef MCU_NWAIT_EN
    output mcu_nwait,
`endif
    output rdaddr, wraddr, be,
    output write, wrdata, proto_err,
    input  rddata
  );

  modport master (
    output mcu_ne, mcu_noe, mcu_nwe,
    output mcu_nbl, mcu_a, mcu_d_in,
    input  mcu_d_out, mcu_d_oe,
`ifdef MCU_NWAIT_EN
    input  mcu_nwait,
`endif
    input  rdaddr, wraddr, be,
    input  write, wrdata, proto_err,
    output rddata
  );
endinterface

// File: rtl/mcu_bus_bridge.sv
// MCU async external bus to single-clock register bus bridge.
// Optional MCU_NWAIT_EN drives mcu_nwait low during read latency.
module mcu_bus_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic aclr_n,
  mcu_bus_bridge_if.slave bus
);

  localparam int W = 36;
  localparam logic [W-1:0] SYNC_RST =
    {3'b111, 2'b11, 15'd0, 16'd0};

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_WAIT, RD_LATCH, RD_HOLD
  } state_e;

  logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;

  logic        s_ne, s_noe, s_nwe;
  logic [1:0]  s_nbl;
  logic [14:0] s_a;
  logic [15:0] s_d;

  state_e      state_q, state_d;
  logic        nwe_prev_q, nwe_prev_d;
  logic        ill_prev_q, ill_prev_d;
  logic        wr_vld_q, wr_vld_d;
  logic [14:0] cap_a_q, cap_a_d;
  logic [15:0] cap_d_q, cap_d_d;
  logic [1:0]  cap_nbl_q, cap_nbl_d;
  logic        write_q, write_d;
  logic [15:0] wraddr_q, wraddr_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] wrdata_q, wrdata_d;
  logic [15:0] rdaddr_q, rdaddr_d;
  logic [15:0] d_out_q, d_out_d;
  logic        d_oe_q, d_oe_d;
  logic        perr_q, perr_d;

  logic ill, rd_req, rd_end;

  // One shared pipeline keeps strobes, address and data aligned.
  always_comb begin
    sync_d = sync_q << W;
    sync_d[0] = {bus.mcu_ne, bus.mcu_noe, bus.mcu_nwe,
                 bus.mcu_nbl, bus.mcu_a, bus.mcu_d_in};
  end

  assign {s_ne, s_noe, s_nwe, s_nbl, s_a, s_d} =
    sync_q[SYNC_STAGES-1];

  assign ill    = ~s_ne & ~s_noe & ~s_nwe;
  assign rd_req = ~s_ne & ~s_noe &  s_nwe;
  assign rd_end =  s_ne |  s_noe;

  always_comb begin
    state_d    = state_q;
    nwe_prev_d = s_nwe;
    ill_prev_d = ill;
    wr_vld_d   = wr_vld_q;
    cap_a_d    = cap_a_q;
    cap_d_d    = cap_d_q;
    cap_nbl_d  = cap_nbl_q;
    write_d    = 1'b0;
    wraddr_d   = wraddr_q;
    be_d       = be_q;
    wrdata_d   = wrdata_q;
    rdaddr_d   = rdaddr_q;
    d_out_d    = d_out_q;
    d_oe_d     = d_oe_q;
    perr_d     = 1'b0;

    if (~s_ne & ~s_nwe & s_noe) begin
      wr_vld_d  = 1'b1;
      cap_a_d   = s_a;
      cap_d_d   = s_d;
      cap_nbl_d = s_nbl;
    end else if (s_nwe & ~nwe_prev_q & wr_vld_q) begin
      wr_vld_d = 1'b0;
      write_d  = 1'b1;
      wraddr_d = {cap_a_q, 1'b0};
      be_d     = ~cap_nbl_q;
      wrdata_d = cap_d_q;
    end

    if (ill) begin
      wr_vld_d = 1'b0;
      state_d  = IDLE;
      d_oe_d   = 1'b0;
      perr_d   = ~ill_prev_q;
    end else begin
      unique case (state_q)
        IDLE:
          if (rd_req) state_d = RD_ADDR;
        RD_ADDR:
          if (rd_end) begin
            state_d = IDLE;
            d_oe_d  = 1'b0;
          end else begin
            state_d  = RD_WAIT;
            rdaddr_d = {s_a, 1'b0};
            d_oe_d   = 1'b1;
          end
        RD_WAIT:
          if (rd_end) begin
            state_d = IDLE;
            d_oe_d  = 1'b0;
          end else begin
            state_d = RD_LATCH;
          end
        RD_LATCH:
          if (rd_end) begin
            state_d = IDLE;
            d_oe_d  = 1'b0;
          end else begin
            state_d = RD_HOLD;
            d_out_d = bus.rddata;
          end
        RD_HOLD:
          if (rd_end) begin
            state_d = IDLE;
            d_oe_d  = 1'b0;
          end
        default: begin
          state_d = IDLE;
          d_oe_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      sync_q     <= {SYNC_STAGES{SYNC_RST}};
      state_q    <= IDLE;
      nwe_prev_q <= 1'b1;
      ill_prev_q <= 1'b0;
      wr_vld_q   <= 1'b0;
      cap_a_q    <= '0;
      cap_d_q    <= '0;
      cap_nbl_q  <= 2'b11;
      write_q    <= 1'b0;
      wraddr_q   <= '0;
      be_q       <= '0;
      wrdata_q   <= '0;
      rdaddr_q   <= '0;
      d_out_q    <= '0;
      d_oe_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      nwe_prev_q <= nwe_prev_d;
      ill_prev_q <= ill_prev_d;
      wr_vld_q   <= wr_vld_d;
      cap_a_q    <= cap_a_d;
      cap_d_q    <= cap_d_d;
      cap_nbl_q  <= cap_nbl_d;
      write_q    <= write_d;
      wraddr_q   <= wraddr_d;
      be_q       <= be_d;
      wrdata_q   <= wrdata_d;
      rdaddr_q   <= rdaddr_d;
      d_out_q    <= d_out_d;
      d_oe_q     <= d_oe_d;
      perr_q     <= perr_d;
    end
  end

`ifdef MCU_NWAIT_EN
  logic nwait_q, nwait_d;

  // Held low one extra cycle after RD_LATCH so mcu_d_out is settled.
  always_comb begin
    nwait_d = ~((state_q == RD_LATCH) |
                (state_d == RD_ADDR)  |
                (state_d == RD_WAIT)  |
                (state_d == RD_LATCH));
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) nwait_q <= 1'b1;
    else         nwait_q <= nwait_d;
  end

  assign bus.mcu_nwait = nwait_q;
`endif

  assign bus.mcu_d_out = d_out_q;
  assign bus.mcu_d_oe  = d_oe_q;
  assign bus.rdaddr    = rdaddr_q;
  assign bus.wraddr    = wraddr_q;
  assign bus.be        = be_q;
  assign bus.write     = write_q;
  assign bus.wrdata    = wrdata_q;
  assign bus.proto_err = perr_q;

endmodule

// File: tb/tb_mcu_bus_bridge.sv
// Directed bench for mcu_bus_bridge: reset, writes, reads,
// protocol error, mid-read reset and optional nwait read.
module tb_mcu_bus_bridge;

  localparam int N = 2;

  logic clk;
  logic aclr_n;
  int   n_chk;
  int   n_bad;
  int   wr_cnt;
  int   pe_cnt;
  bit   doe_seen;
  int   wr0;
  int   pe0;

  mcu_bus_bridge_if bus();

  mcu_bus_bridge #(.SYNC_STAGES(N)) dut (
    .clk   (clk),
    .aclr_n(aclr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: registered read data, rdaddr ^ 16'hA5FF.
  always @(posedge clk) bus.rddata <= bus.rdaddr ^ 16'hA5FF;

  always @(posedge clk) begin
    if (bus.write)     wr_cnt++;
    if (bus.proto_err) pe_cnt++;
    if (bus.mcu_d_oe)  doe_seen = 1'b1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_pins();
    bus.mcu_ne   = 1'b1;
    bus.mcu_noe  = 1'b1;
    bus.mcu_nwe  = 1'b1;
    bus.mcu_nbl  = 2'b11;
  endtask

  initial begin
    n_chk  = 0;
    n_bad  = 0;
    wr_cnt = 0;
    pe_cnt = 0;
    doe_seen = 1'b0;
    bus.rddata   = 16'h0000;
    bus.mcu_a    = 15'h0000;
    bus.mcu_d_in = 16'h0000;
    idle_pins();
    aclr_n = 1'b0;
    step(3);
    aclr_n = 1'b1;
    step(100);

    chk("rst_write_cnt", 32'(wr_cnt), 0);
    chk("rst_perr_cnt", 32'(pe_cnt), 0);
    chk("rst_doe", 32'(bus.mcu_d_oe), 0);
    chk("rst_dout", 32'(bus.mcu_d_out), 0);
    chk("rst_rdaddr", 32'(bus.rdaddr), 0);
    chk("rst_wraddr", 32'(bus.wraddr), 0);
    chk("rst_be", 32'(bus.be), 0);
    chk("rst_wrdata", 32'(bus.wrdata), 0);
`ifdef MCU_NWAIT_EN
    chk("rst_nwait", 32'(bus.mcu_nwait), 1);
`endif

    // Write 1: a=0011, d=1234, nbl=10
    bus.mcu_a    = 15'h0011;
    bus.mcu_d_in = 16'h1234;
    bus.mcu_nbl  = 2'b10;
    bus.mcu_ne   = 1'b0;
    bus.mcu_nwe  = 1'b0;
    step(4);
    wr0 = wr_cnt;
    bus.mcu_nwe = 1'b1;
    bus.mcu_ne  = 1'b1;
    step(N);
    chk("wr1_early", 32'(bus.write), 0);
    step(1);
    chk("wr1_strobe", 32'(bus.write), 1);
    chk("wr1_wraddr", 32'(bus.wraddr), 32'h0022);
    chk("wr1_be", 32'(bus.be), 32'h1);
    chk("wr1_wrdata", 32'(bus.wrdata), 32'h1234);
    step(1);
    chk("wr1_one_cycle", 32'(bus.write), 0);
    step(N + 2);
    chk("wr1_pulses", 32'(wr_cnt - wr0), 1);
    chk("wr1_hold", 32'(bus.wrdata), 32'h1234);

    // Write 2: all byte lanes off still strobes
    bus.mcu_a    = 15'h7FFF;
    bus.mcu_d_in = 16'hFFFF;
    bus.mcu_nbl  = 2'b11;
    bus.mcu_ne   = 1'b0;
    bus.mcu_nwe  = 1'b0;
    step(2);
    bus.mcu_nwe = 1'b1;
    bus.mcu_ne  = 1'b1;
    step(N + 1);
    chk("wr2_strobe", 32'(bus.write), 1);
    chk("wr2_wraddr", 32'(bus.wraddr), 32'hFFFE);
    chk("wr2_be", 32'(bus.be), 32'h0);
    chk("wr2_wrdata", 32'(bus.wrdata), 32'hFFFF);
    step(N + 2);

    // Read: a=001E -> rdaddr 003C -> rddata A5C3
    wr0 = wr_cnt;
    bus.mcu_a   = 15'h001E;
    bus.mcu_ne  = 1'b0;
    bus.mcu_noe = 1'b0;
    step(N + 3);
    chk("rd_rdaddr", 32'(bus.rdaddr), 32'h003C);
    chk("rd_doe", 32'(bus.mcu_d_oe), 1);
    chk("rd_dout_early", 32'(bus.mcu_d_out), 0);
    step(1);
    chk("rd_dout", 32'(bus.mcu_d_out), 32'hA5C3);
    step(4);
    chk("rd_dout_hold", 32'(bus.mcu_d_out), 32'hA5C3);
    bus.mcu_noe = 1'b1;
    bus.mcu_ne  = 1'b1;
    step(N);
    chk("rd_doe_before", 32'(bus.mcu_d_oe), 1);
    step(1);
    chk("rd_doe_off", 32'(bus.mcu_d_oe), 0);
    step(N + 2);
    chk("rd_no_write", 32'(wr_cnt - wr0), 0);

    // Illegal: noe and nwe low together
    wr0 = wr_cnt;
    pe0 = pe_cnt;
    doe_seen = 1'b0;
    bus.mcu_a    = 15'h0040;
    bus.mcu_d_in = 16'hBEEF;
    bus.mcu_nbl  = 2'b00;
    bus.mcu_ne   = 1'b0;
    bus.mcu_noe  = 1'b0;
    bus.mcu_nwe  = 1'b0;
    step(8);
    idle_pins();
    step(N + 4);
    chk("pe_pulses", 32'(pe_cnt - pe0), 1);
    chk("pe_no_write", 32'(wr_cnt - wr0), 0);
    chk("pe_doe_seen", 32'(doe_seen), 0);
    chk("pe_wrdata_kept", 32'(bus.wrdata), 32'hFFFF);

    // Reset during RD_WAIT
    wr0 = wr_cnt;
    bus.mcu_a   = 15'h001E;
    bus.mcu_ne  = 1'b0;
    bus.mcu_noe = 1'b0;
    step(N + 2);
    chk("rst_mid_doe_pre", 32'(bus.mcu_d_oe), 1);
    aclr_n = 1'b0;
    #1;
    chk("rst_mid_doe", 32'(bus.mcu_d_oe), 0);
    chk("rst_mid_rdaddr", 32'(bus.rdaddr), 0);
    chk("rst_mid_dout", 32'(bus.mcu_d_out), 0);
    idle_pins();
    step(2);
    aclr_n = 1'b1;
    step(N + 3);
    chk("rst_mid_idle_doe", 32'(bus.mcu_d_oe), 0);

    // Next read after reset: a=0005 -> 000A ^ A5FF = A5F5
    bus.mcu_a   = 15'h0005;
    bus.mcu_ne  = 1'b0;
    bus.mcu_noe = 1'b0;
    step(N + 4);
    chk("rd2_rdaddr", 32'(bus.rdaddr), 32'h000A);
    chk("rd2_dout", 32'(bus.mcu_d_out), 32'hA5F5);
    chk("rd2_doe", 32'(bus.mcu_d_oe), 1);
    idle_pins();
    step(N + 3);
    chk("rd2_doe_off", 32'(bus.mcu_d_oe), 0);
    chk("rd2_no_write", 32'(wr_cnt - wr0), 0);

`ifdef MCU_NWAIT_EN
    // MCU requests a short read and stretches it on nwait.
    begin
      int t;
      bus.mcu_a   = 15'h001E;
      bus.mcu_ne  = 1'b0;
      bus.mcu_noe = 1'b0;
      t = 0;
      while (bus.mcu_nwait && t < 20) begin
        step(1);
        t++;
      end
      chk("nw_low_seen", 32'(t < 20), 1);
      t = 0;
      while (!bus.mcu_nwait && t < 20) begin
        step(1);
        t++;
      end
      chk("nw_low_len", 32'(t), 4);
      chk("nw_dout", 32'(bus.mcu_d_out), 32'hA5C3);
      chk("nw_doe", 32'(bus.mcu_d_oe), 1);
      idle_pins();
      step(N + 3);
      chk("nw_doe_off", 32'(bus.mcu_d_oe), 0);
      chk("nw_dout_kept", 32'(bus.mcu_d_out), 32'hA5C3);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
